// File: rtl/dmem_arbiter.sv
// Shares one single-ported byte memory between instruction fetch and MEM-stage load/store.
// Define MISALIGN_CHK_EN to block misaligned accesses and flag them through i_err/d_err.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_fun3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_fun3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_D    = 2'b01,
    S_I    = 2'b10
  } state_t;

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);
  localparam logic [2:0] LP_FUN3_LW  = 3'b010;

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic        r_i_valid;
  logic        r_d_valid;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        w_i_elig;
  logic        w_d_elig;
  logic        w_i_pri;
  logic        w_i_gnt;
  logic        w_d_gnt;
  logic        w_i_mis;
  logic        w_d_mis;

`ifdef MISALIGN_CHK_EN
  logic r_i_err;
  logic r_d_err;

  function automatic logic f_misaligned(input logic [2:0] fun3, input logic [1:0] addr_lo);
    logic v_mis;
    case (fun3[1:0])
      2'b01:   v_mis = addr_lo[0];
      2'b10:   v_mis = (addr_lo != 2'b00);
      default: v_mis = 1'b0;
    endcase
    return v_mis;
  endfunction

  assign w_d_mis = f_misaligned(d_fun3, d_addr[1:0]);
  assign w_i_mis = f_misaligned(LP_FUN3_LW, i_addr[1:0]);
  assign i_err   = r_i_err;
  assign d_err   = r_d_err;
`else
  assign w_d_mis = 1'b0;
  assign w_i_mis = 1'b0;
  assign i_err   = 1'b0;
  assign d_err   = 1'b0;
`endif

  // A requester sits out its own response cycle so a req that is being dropped is never served twice.
  assign w_d_elig = d_req & (r_state != S_D) & ~rst;
  assign w_i_elig = i_req & (r_state != S_I) & ~rst;
  assign w_i_pri  = (r_wait_cnt == LP_MAX_WAIT);
  assign w_d_gnt  = w_d_elig & ~(w_i_elig & w_i_pri);
  assign w_i_gnt  = w_i_elig & ~w_d_gnt;

  assign i_gnt   = w_i_gnt;
  assign d_gnt   = w_d_gnt;
  assign i_valid = r_i_valid;
  assign d_valid = r_d_valid;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

  // Memory pins follow the winning requester; misaligned accesses keep both strobes low.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_fun3  = 3'b000;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = 32'h0000_0000;
    if (w_d_gnt) begin
      mem_read  = ~d_we & ~w_d_mis;
      mem_write = d_we & ~w_d_mis;
      mem_fun3  = d_fun3;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_i_gnt) begin
      mem_read  = ~w_i_mis;
      mem_write = 1'b0;
      mem_fun3  = LP_FUN3_LW;
      mem_addr  = i_addr;
      mem_wdata = 32'h0000_0000;
    end else begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  // Grant-tracking FSM, starvation counter and registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_i_valid  <= 1'b0;
      r_d_valid  <= 1'b0;
      r_i_rdata  <= 32'h0000_0000;
      r_d_rdata  <= 32'h0000_0000;
`ifdef MISALIGN_CHK_EN
      r_i_err    <= 1'b0;
      r_d_err    <= 1'b0;
`endif
    end else begin
      if (w_d_gnt) begin
        r_state <= S_D;
      end else if (w_i_gnt) begin
        r_state <= S_I;
      end else begin
        r_state <= S_IDLE;
      end

      if (w_i_gnt) begin
        r_wait_cnt <= 4'd0;
      end else if (w_i_elig && (r_wait_cnt < LP_MAX_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end

      r_d_valid <= w_d_gnt;
      r_i_valid <= w_i_gnt;

      if (w_d_gnt) begin
        r_d_rdata <= (d_we | w_d_mis) ? 32'h0000_0000 : mem_rdata;
      end
      if (w_i_gnt) begin
        r_i_rdata <= w_i_mis ? 32'h0000_0000 : mem_rdata;
      end
`ifdef MISALIGN_CHK_EN
      if (w_d_gnt) begin
        r_d_err <= w_d_mis;
      end
      if (w_i_gnt) begin
        r_i_err <= w_i_mis;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x8 little-endian memory preloaded mem[k] = k.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_gnt;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_fun3;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_fun3;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        mem_init;
  logic [7:0]  mem [256];
  logic [7:0]  rb0, rb1, rb2, rb3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_fun3(d_fun3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_fun3(mem_fun3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Combinational memory read, sign/zero extension by fun3; undefined fun3 reads 0.
  always_comb begin
    rb0 = mem[mem_addr];
    rb1 = mem[8'(mem_addr + 8'd1)];
    rb2 = mem[8'(mem_addr + 8'd2)];
    rb3 = mem[8'(mem_addr + 8'd3)];
    mem_rdata = 32'h0;
    if (mem_read) begin
      case (mem_fun3)
        3'b000:  mem_rdata = {{24{rb0[7]}}, rb0};
        3'b001:  mem_rdata = {{16{rb1[7]}}, rb1, rb0};
        3'b010:  mem_rdata = {rb3, rb2, rb1, rb0};
        3'b100:  mem_rdata = {24'h0, rb0};
        3'b101:  mem_rdata = {16'h0, rb1, rb0};
        default: mem_rdata = 32'h0;
      endcase
    end
  end

  // Memory preload and posedge writes; undefined store widths are ignored.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (mem_write) begin
      case (mem_fun3)
        3'b000: mem[mem_addr] <= mem_wdata[7:0];
        3'b001: begin
          mem[mem_addr]               <= mem_wdata[7:0];
          mem[8'(mem_addr + 8'd1)]    <= mem_wdata[15:8];
        end
        3'b010: begin
          mem[mem_addr]               <= mem_wdata[7:0];
          mem[8'(mem_addr + 8'd1)]    <= mem_wdata[15:8];
          mem[8'(mem_addr + 8'd2)]    <= mem_wdata[23:16];
          mem[8'(mem_addr + 8'd3)]    <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One data access from an idle arbiter: grant cycle, then response cycle.
  task automatic d_access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [7:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input logic exp_en);
    d_req = 1'b1; d_we = we; d_fun3 = f3; d_addr = a; d_wdata = wd;
    @(negedge clk);
    check({tag, " d_gnt"}, 32'(d_gnt), 32'd1);
    check({tag, " mem_read"}, 32'(mem_read), 32'(exp_en & ~we));
    check({tag, " mem_write"}, 32'(mem_write), 32'(exp_en & we));
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(a));
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    check({tag, " d_valid"}, 32'(d_valid), 32'd1);
    check({tag, " d_rdata"}, d_rdata, exp_rd);
    check({tag, " d_err"}, 32'(d_err), 32'(exp_err));
    check({tag, " idle mem_read"}, 32'(mem_read), 32'd0);
    next_cycle();
  endtask

  task automatic i_access(input string tag, input logic [7:0] a,
                          input logic [31:0] exp_rd, input logic exp_err, input logic exp_en);
    i_req = 1'b1; i_addr = a;
    @(negedge clk);
    check({tag, " i_gnt"}, 32'(i_gnt), 32'd1);
    check({tag, " mem_read"}, 32'(mem_read), 32'(exp_en));
    check({tag, " mem_fun3"}, 32'(mem_fun3), 32'd2);
    next_cycle();
    i_req = 1'b0;
    @(negedge clk);
    check({tag, " i_valid"}, 32'(i_valid), 32'd1);
    check({tag, " i_rdata"}, i_rdata, exp_rd);
    check({tag, " i_err"}, 32'(i_err), 32'(exp_err));
    next_cycle();
  endtask

  initial begin
    logic [3:0] exp_dg, exp_ig, exp_dv, exp_iv, exp_wc;

    // Reset with a store and a fetch presented: nothing may reach memory.
    rst = 1'b1; mem_init = 1'b1;
    i_req = 1'b1; i_addr = 8'd0;
    d_req = 1'b1; d_we = 1'b1; d_fun3 = 3'b010; d_addr = 8'd12; d_wdata = 32'h1122_3344;
    @(negedge clk);
    check("rst d_gnt", 32'(d_gnt), 32'd0);
    check("rst i_gnt", 32'(i_gnt), 32'd0);
    check("rst mem_write", 32'(mem_write), 32'd0);
    check("rst mem_read", 32'(mem_read), 32'd0);
    next_cycle();
    mem_init = 1'b0;
    @(negedge clk);
    check("rst i_valid", 32'(i_valid), 32'd0);
    check("rst d_valid", 32'(d_valid), 32'd0);
    check("rst i_rdata", i_rdata, 32'd0);
    check("rst d_rdata", d_rdata, 32'd0);
    check("rst i_err", 32'(i_err), 32'd0);
    check("rst d_err", 32'(d_err), 32'd0);
    check("rst wait_cnt", 32'(dut.r_wait_cnt), 32'd0);
    next_cycle();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    next_cycle();

    d_access("lw4", 1'b0, 3'b010, 8'd4, 32'h0, 32'h0706_0504, 1'b0, 1'b1);
    d_access("lw12 after rst", 1'b0, 3'b010, 8'd12, 32'h0, 32'h0F0E_0D0C, 1'b0, 1'b1);
`ifdef MISALIGN_CHK_EN
    d_access("lw5 mis", 1'b0, 3'b010, 8'd5, 32'h0, 32'h0, 1'b1, 1'b0);
    d_access("lh1 mis", 1'b0, 3'b001, 8'd1, 32'h0, 32'h0, 1'b1, 1'b0);
    i_access("if2 mis", 8'd2, 32'h0, 1'b1, 1'b0);
`else
    d_access("lw5", 1'b0, 3'b010, 8'd5, 32'h0, 32'h0807_0605, 1'b0, 1'b1);
    d_access("lh1", 1'b0, 3'b001, 8'd1, 32'h0, 32'h0000_0201, 1'b0, 1'b1);
    i_access("if2", 8'd2, 32'h0504_0302, 1'b0, 1'b1);
`endif
    i_access("if16", 8'd16, 32'h1312_1110, 1'b0, 1'b1);

    d_access("sb8", 1'b1, 3'b000, 8'd8, 32'h0000_00AB, 32'h0, 1'b0, 1'b1);
    d_access("lbu8", 1'b0, 3'b100, 8'd8, 32'h0, 32'h0000_00AB, 1'b0, 1'b1);
    d_access("lb8", 1'b0, 3'b000, 8'd8, 32'h0, 32'hFFFF_FFAB, 1'b0, 1'b1);
    d_access("sw20", 1'b1, 3'b010, 8'd20, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    d_access("lh22", 1'b0, 3'b001, 8'd22, 32'h0, 32'hFFFF_DEAD, 1'b0, 1'b1);
    d_access("lhu20", 1'b0, 3'b101, 8'd20, 32'h0, 32'h0000_BEEF, 1'b0, 1'b1);
    d_access("ld f3=011", 1'b0, 3'b011, 8'd4, 32'h0, 32'h0, 1'b0, 1'b1);
    d_access("st f3=111", 1'b1, 3'b111, 8'd4, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    d_access("lw4 unchanged", 1'b0, 3'b010, 8'd4, 32'h0, 32'h0706_0504, 1'b0, 1'b1);

    // Both request once together: data first, fetch granted during S_D.
    d_req = 1'b1; d_we = 1'b0; d_fun3 = 3'b010; d_addr = 8'd4;
    i_req = 1'b1; i_addr = 8'd16;
    @(negedge clk);
    check("once c0 d_gnt", 32'(d_gnt), 32'd1);
    check("once c0 i_gnt", 32'(i_gnt), 32'd0);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    check("once c1 i_gnt", 32'(i_gnt), 32'd1);
    check("once c1 d_gnt", 32'(d_gnt), 32'd0);
    check("once c1 d_valid", 32'(d_valid), 32'd1);
    check("once c1 d_rdata", d_rdata, 32'h0706_0504);
    next_cycle();
    i_req = 1'b0;
    @(negedge clk);
    check("once c2 i_valid", 32'(i_valid), 32'd1);
    check("once c2 i_rdata", i_rdata, 32'h1312_1110);
    check("once c2 d_valid", 32'(d_valid), 32'd0);
    check("once c2 d_gnt", 32'(d_gnt), 32'd0);
    next_cycle();

    // Both held high: grants alternate, wait_cnt only counts the one denied cycle.
    exp_dg = 4'b0101; exp_ig = 4'b1010; exp_dv = 4'b1010; exp_iv = 4'b0100; exp_wc = 4'b0010;
    d_req = 1'b1; i_req = 1'b1; i_addr = 8'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("held c%0d d_gnt", c), 32'(d_gnt), 32'(exp_dg[c]));
      check($sformatf("held c%0d i_gnt", c), 32'(i_gnt), 32'(exp_ig[c]));
      check($sformatf("held c%0d d_valid", c), 32'(d_valid), 32'(exp_dv[c]));
      check($sformatf("held c%0d i_valid", c), 32'(i_valid), 32'(exp_iv[c]));
      check($sformatf("held c%0d wait_cnt", c), 32'(dut.r_wait_cnt), 32'(exp_wc[c]));
      if (exp_iv[c]) check("held i_rdata", i_rdata, 32'h0302_0100);
      if (exp_dv[c]) check("held d_rdata", d_rdata, 32'h0706_0504);
      next_cycle();
    end
    d_req = 1'b0; i_req = 1'b0;
    @(negedge clk);
    check("held c4 i_valid", 32'(i_valid), 32'd1);
    check("held c4 wait_cnt", 32'(dut.r_wait_cnt), 32'd0);
    next_cycle();

    // A lone requester holding req is served every second cycle.
    exp_ig = 4'b0101; exp_iv = 4'b1010;
    i_req = 1'b1; i_addr = 8'd16;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("solo c%0d i_gnt", c), 32'(i_gnt), 32'(exp_ig[c]));
      check($sformatf("solo c%0d i_valid", c), 32'(i_valid), 32'(exp_iv[c]));
      next_cycle();
    end
    i_req = 1'b0;
    next_cycle();

    // Reset during a response and a presented store: valids cleared, store dropped.
    d_req = 1'b1; d_we = 1'b0; d_fun3 = 3'b010; d_addr = 8'd4;
    @(negedge clk);
    check("rst2 pre d_gnt", 32'(d_gnt), 32'd1);
    next_cycle();
    rst = 1'b1; d_we = 1'b1; d_addr = 8'd12; d_wdata = 32'h1122_3344;
    i_req = 1'b1; i_addr = 8'd0;
    @(negedge clk);
    check("rst2 d_gnt", 32'(d_gnt), 32'd0);
    check("rst2 i_gnt", 32'(i_gnt), 32'd0);
    check("rst2 mem_write", 32'(mem_write), 32'd0);
    next_cycle();
    rst = 1'b0; d_req = 1'b0; i_req = 1'b0;
    @(negedge clk);
    check("rst2 d_valid", 32'(d_valid), 32'd0);
    check("rst2 i_valid", 32'(i_valid), 32'd0);
    check("rst2 d_rdata", d_rdata, 32'd0);
    check("rst2 state", 32'(dut.r_state), 32'd0);
    next_cycle();
    d_access("lw12 after rst2", 1'b0, 3'b010, 8'd12, 32'h0, 32'h0F0E_0D0C, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
